// File: rtl/difftest_load_event_queue_pkg.sv
// Shared types for the difftest load-event path: the record carried from the
// LSU writeback port through to DifftestLoadEvent.
package difftest_pkg;

   localparam int DIFFTEST_INDEX_W = 8;

   typedef struct packed {
      logic [63:0] paddr;
      logic [7:0]  opType;
      logic        isAtomic;
      logic        isLoad;
   } load_event_t;

endpackage

// File: rtl/difftest_load_event_queue_if.sv
// Writeback, commit, flush and event-output bundle of the load event queue.
// The slave view belongs to the queue and the master view to its driver.
interface difftest_load_event_queue_if #(
   parameter int DEPTH     = 8,
   parameter int ROB_IDX_W = 6
);
   import difftest_pkg::*;

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                        wb_valid;
   logic                        wb_ready;
   logic [ROB_IDX_W-1:0]        wb_rob_idx;
   logic [63:0]                 wb_paddr;
   logic [7:0]                  wb_opType;
   logic                        wb_isAtomic;
   logic                        wb_isLoad;
   logic                        commit_valid;
   logic [ROB_IDX_W-1:0]        commit_rob_idx;
   logic                        flush;
   logic                        out_enable;
   logic [63:0]                 out_paddr;
   logic [7:0]                  out_opType;
   logic                        out_isAtomic;
   logic                        out_isLoad;
   logic [7:0]                  out_coreid;
   logic [DIFFTEST_INDEX_W-1:0] out_index;
   logic                        err_mismatch;
   logic [CNT_W-1:0]            count;

   modport master (
      output wb_valid, wb_rob_idx, wb_paddr, wb_opType, wb_isAtomic, wb_isLoad,
      output commit_valid, commit_rob_idx, flush,
      input  wb_ready, out_enable, out_paddr, out_opType, out_isAtomic, out_isLoad,
      input  out_coreid, out_index, err_mismatch, count
   );

   modport slave (
      input  wb_valid, wb_rob_idx, wb_paddr, wb_opType, wb_isAtomic, wb_isLoad,
      input  commit_valid, commit_rob_idx, flush,
      output wb_ready, out_enable, out_paddr, out_opType, out_isAtomic, out_isLoad,
      output out_coreid, out_index, err_mismatch, count
   );

endinterface

// File: rtl/difftest_load_event_queue_fifo.sv
// Generic circular FIFO whose pointers carry one extra MSB to tell full from
// empty. Flush snaps tail onto the post-pop head and suppresses that cycle's push.
module difftest_event_fifo #(
   parameter int  DEPTH = 8,
   parameter type T     = logic [7:0]
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_push,
   input  T                       i_data,
   input  logic                   i_pop,
   input  logic                   i_flush,
   output T                       o_head,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int AW = $clog2(DEPTH);

   T             r_mem [DEPTH];
   logic [AW:0]  r_head;
   logic [AW:0]  r_tail;
   logic [AW:0]  w_head_nxt;
   logic         w_pop;
   logic         w_push;

   assign o_empty    = (r_head == r_tail);
   assign o_full     = (r_head[AW] != r_tail[AW]) && (r_head[AW-1:0] == r_tail[AW-1:0]);
   assign o_count    = r_tail - r_head;
   assign o_head     = r_mem[r_head[AW-1:0]];
   assign w_pop      = i_pop && !o_empty;
   assign w_push     = i_push && !o_full && !i_flush;
   assign w_head_nxt = r_head + {{AW{1'b0}}, w_pop};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_head <= '0;
         r_tail <= '0;
      end else begin
         r_head <= w_head_nxt;
         if (i_flush)
            r_tail <= w_head_nxt;
         else if (w_push)
            r_tail <= r_tail + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push)
         r_mem[r_tail[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/difftest_load_event_queue.sv
// Holds LSU load/atomic writeback records until their instruction commits, then
// emits one registered DifftestLoadEvent per committed record in program order.
module difftest_load_event_queue
   import difftest_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int ROB_IDX_W = 6,
   parameter int COREID    = 0
) (
   input  logic                   clock,
   input  logic                   reset,
   difftest_load_event_queue_if.slave io
);
   typedef struct packed {
      logic [ROB_IDX_W-1:0] rob_idx;
      load_event_t          ev;
   } entry_t;

   entry_t                      w_wb_entry;
   entry_t                      w_head;
   logic                        w_full;
   logic                        w_empty;
   logic                        w_match;
   logic [$clog2(DEPTH):0]      w_count;

   logic                        r_out_enable;
   load_event_t                 r_out_ev;
   logic [DIFFTEST_INDEX_W-1:0] r_out_index;
   logic [DIFFTEST_INDEX_W-1:0] r_evt_cnt;
   logic                        r_err;

   assign w_wb_entry.rob_idx     = io.wb_rob_idx;
   assign w_wb_entry.ev.paddr    = io.wb_paddr;
   assign w_wb_entry.ev.opType   = io.wb_opType;
   assign w_wb_entry.ev.isAtomic = io.wb_isAtomic;
   assign w_wb_entry.ev.isLoad   = io.wb_isLoad;

   // Only the current head may retire; a same-cycle writeback is never bypassed.
   assign w_match = io.commit_valid && !w_empty && (w_head.rob_idx == io.commit_rob_idx);

   difftest_event_fifo #(
      .DEPTH (DEPTH),
      .T     (entry_t)
   ) u_fifo (
      .i_clk   (clock),
      .i_rst   (reset),
      .i_push  (io.wb_valid),
      .i_data  (w_wb_entry),
      .i_pop   (w_match),
      .i_flush (io.flush),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_out_enable <= 1'b0;
         r_out_ev     <= '0;
         r_out_index  <= '0;
         r_evt_cnt    <= '0;
         r_err        <= 1'b0;
      end else begin
         r_out_enable <= w_match;
         if (w_match) begin
            r_out_ev    <= w_head.ev;
            r_out_index <= r_evt_cnt;
            r_evt_cnt   <= r_evt_cnt + 1'b1;
         end
         if (io.commit_valid && !w_match)
            r_err <= 1'b1;
      end
   end

   assign io.wb_ready     = !w_full;
   assign io.count        = w_count;
   assign io.out_enable   = r_out_enable;
   assign io.out_paddr    = r_out_ev.paddr;
   assign io.out_opType   = r_out_ev.opType;
   assign io.out_isAtomic = r_out_ev.isAtomic;
   assign io.out_isLoad   = r_out_ev.isLoad;
   assign io.out_coreid   = 8'(COREID);
   assign io.out_index    = r_out_index;
   assign io.err_mismatch = r_err;

endmodule

// File: doc/difftest_load_event_queue.md
# difftest_load_event_queue

Buffers load/atomic completion records from the load-store unit's writeback port. Holds each record until the matching instruction commits, then emits exactly one registered event per committed load to DifftestLoadEvent, in program order. Sits directly upstream of DifftestLoadEvent. Its outputs drive that module's `enable` and `io_*` ports one-to-one.

## Interface
- DEPTH, 8: queue entries; power of two, 2..64
- ROB_IDX_W, 6: width of ROB tag
- COREID, 0: constant driven on out_coreid
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- wb_valid  in  1  load/atomic writeback record offered
- wb_ready  out  1  queue can accept; equals !full
- wb_rob_idx  in  ROB_IDX_W  ROB tag of the record
- wb_paddr  in  64  physical address
- wb_opType  in  8  LSU op type
- wb_isAtomic  in  1  record is AMO/LR/SC
- wb_isLoad  in  1  record is plain load
- commit_valid  in  1  a load/atomic instruction retires this cycle; at most one per cycle
- commit_rob_idx  in  ROB_IDX_W  its ROB tag
- flush  in  1  pipeline redirect; squash all uncommitted entries
- out_enable  out  1  one-cycle pulse; drives enable and io_valid
- out_paddr, out_opType, out_isAtomic, out_isLoad  out  64/8/1/1  record fields
- out_coreid  out  8  COREID[7:0]
- out_index  out  8  event sequence number
- err_mismatch  out  1  sticky; commit without a matching head entry
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Circular FIFO with head and tail pointers of $clog2(DEPTH)+1 bits. The MSB distinguishes full from empty.
  - full: pointers equal except MSB.
  - empty: pointers fully equal.
- Enqueue: wb_valid && wb_ready writes the record at tail; tail increments, wrapping modulo 2·DEPTH.
  - The LSU writes back in program order for loads. The queue itself does no reordering.
- Commit, when commit_valid=1:
  - If !empty and head.rob_idx == commit_rob_idx: pop head and latch its fields into the output registers; out_enable=1 next cycle.
  - Otherwise, err_mismatch sets and stays 1 until reset. Nothing is popped and out_enable stays 0.
- out_index: 8-bit counter, reset 0, increments after each emitted event, wraps 255→0. The emitted value is the pre-increment count, so the first event carries 0.
- Flush: tail ← head, which empties the queue after any same-cycle commit pop is applied. Entries already emitted are unaffected.
- Simultaneous events in one cycle, resolved in this order:
  1. commit
  2. flush
  3. enqueue
- Flush and wb_valid in the same cycle: the wb record is dropped. wb_ready is still driven as !full, but the write is suppressed.
- Full queue with commit pop in the same cycle: wb_ready=0 (no bypass). Enqueue is accepted the following cycle.
- Empty queue with wb_valid and a matching commit in the same cycle: no bypass; the commit is a mismatch. Writeback must lead commit by ≥1 cycle.
- Reset mid-operation clears the following next edge; no event is emitted for discarded entries.
  - Reset values: head, tail, count, out_index, out_enable, err_mismatch = 0.
  - Output data registers = 0.

## Timing
- Enqueue to commit-eligible: 1 cycle; an entry is visible at head the cycle after its write.
- Commit to out_enable: 1 cycle; all outputs are registered.
- Throughput: 1 enqueue and 1 emit per cycle, sustained.
- out_enable is a single-cycle pulse per event. Output data holds its value until the next event.
- count updates the cycle after the enqueue/pop/flush that changes it.

## Structure
- Shared package difftest_pkg:
  - typedef load_event_t {paddr[63:0], opType[7:0], isAtomic, isLoad}
  - constant DIFFTEST_INDEX_W = 8
- Sub-module difftest_event_fifo: generic storage plus pointer/full/empty logic, parameterised on DEPTH and the entry type.
- The top level adds the tag-compare, commit/flush priority, output registers, index counter and error flag.

## Test plan
- Basic: enqueue rob 3, paddr 0x8000_1000, op 0x02, isLoad=1; commit rob 3 two cycles later → one out_enable pulse one cycle after commit with those fields, out_index=0, out_coreid=COREID.
- Back-to-back: enqueue rob 0..7 on consecutive cycles, then commit 0..7 on consecutive cycles → 8 consecutive pulses, in order, out_index 0..7.
- Full and wrap-around (DEPTH=8):
  - Fill 8 entries: wb_ready=0, count=8.
  - Commit one with wb_valid held: record accepted the next cycle.
  - Run 20 total events: tail wraps correctly, out_index reaches 19.
- Flush: 4 entries queued; commit head and flush in the same cycle → exactly 1 event, count=0, subsequent commit of squashed tag sets err_mismatch.
- Mismatch: head rob 5, commit rob 6 → no pulse, err_mismatch=1 and remains 1; head still rob 5.
- Reset mid-run and index wrap:
  - Assert reset with 3 entries queued: count=0, no events emitted, out_index=0.
  - After 256 events, out_index wraps to 0.
